// File: rtl/rx_vp_mon.sv
// rx_vp_mon: vertical-sync monitor that measures the strobe period, classifies 59.94/60 Hz vs 50 Hz and qualifies lock
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active-high
//   vs_in   raw asynchronous vertical sync from the receiver
//   rx_vp   qualified one-cycle vertical pulse
//   rx_ok   lock indicator
//   f50hz   1 = 50 Hz class, 0 = 59.94/60 Hz class (kept across lock loss)
//   vp_err  one-cycle pulse on each out-of-window edge
//   period  last measured edge-to-edge period in clk cycles
module rx_vp_mon #(
    parameter int PW       = 22,
    parameter int F59_MIN  = 2060000,
    parameter int F59_MAX  = 2110000,
    parameter int F50_MIN  = 2470000,
    parameter int F50_MAX  = 2530000,
    parameter int TMO      = 2600000,
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs_in,
    output logic          rx_vp,
    output logic          rx_ok,
    output logic          f50hz,
    output logic          vp_err,
    output logic [PW-1:0] period
);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam int MW = $clog2(UNLOCK_N + 1);
    typedef enum logic [1:0] {UNLOCK, ACQ, LOCK} state_t;
    state_t state, state_n;
    logic s1, s2, s3, vs_edge;
    logic [PW-1:0] pcnt, period_n;
    logic cls, cls_n, is59, is50, good, same;
    logic [GW-1:0] good_cnt, good_n;
    logic [MW-1:0] miss_cnt, miss_n;
    logic rx_vp_n, rx_ok_n, f50_n, err_n;
    assign vs_edge = s2 & ~s3;
    assign is59 = pcnt >= PW'(F59_MIN) && pcnt <= PW'(F59_MAX);
    assign is50 = pcnt >= PW'(F50_MIN) && pcnt <= PW'(F50_MAX);
    assign good = is59 | is50;
    // cls encodes the tracked class: 1 = 50 Hz, 0 = 59.94/60 Hz
    assign same = good && (is50 == cls);
    always_comb begin
        state_n  = state;
        cls_n    = cls;
        good_n   = good_cnt;
        miss_n   = miss_cnt;
        rx_vp_n  = 1'b0;
        err_n    = 1'b0;
        rx_ok_n  = rx_ok;
        f50_n    = f50hz;
        period_n = period;
        if (vs_edge) begin
            // the first edge after UNLOCK only restarts measurement
            if (state != UNLOCK) period_n = pcnt;
            case (state)
                UNLOCK: begin
                    state_n = ACQ;
                    good_n  = '0;
                end
                ACQ: begin
                    if (!good) begin
                        err_n  = 1'b1;
                        good_n = '0;
                    end else if (!same) begin
                        cls_n  = is50;
                        good_n = GW'(1);
                    end else begin
                        good_n = good_cnt + GW'(1);
                        if (good_cnt + GW'(1) == GW'(LOCK_N)) begin
                            state_n = LOCK;
                            rx_ok_n = 1'b1;
                            f50_n   = cls;
                            miss_n  = '0;
                            rx_vp_n = 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (same) begin
                        rx_vp_n = 1'b1;
                        miss_n  = '0;
                    end else begin
                        err_n  = 1'b1;
                        miss_n = miss_cnt + MW'(1);
                        if (miss_cnt + MW'(1) == MW'(UNLOCK_N)) begin
                            state_n = ACQ;
                            rx_ok_n = 1'b0;
                            good_n  = '0;
                        end
                    end
                end
                default: state_n = UNLOCK;
            endcase
        end else if (state != UNLOCK && pcnt == PW'(TMO)) begin
            state_n = UNLOCK;
            rx_ok_n = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1, s2, s3} <= '0;
            pcnt         <= '0;
            state        <= UNLOCK;
            cls          <= 1'b0;
            good_cnt     <= '0;
            miss_cnt     <= '0;
            rx_vp        <= 1'b0;
            rx_ok        <= 1'b0;
            f50hz        <= 1'b0;
            vp_err       <= 1'b0;
            period       <= '0;
        end else begin
            s1       <= vs_in;
            s2       <= s1;
            s3       <= s2;
            pcnt     <= vs_edge ? PW'(1) : (&pcnt ? pcnt : pcnt + PW'(1));
            state    <= state_n;
            cls      <= cls_n;
            good_cnt <= good_n;
            miss_cnt <= miss_n;
            rx_vp    <= rx_vp_n;
            rx_ok    <= rx_ok_n;
            f50hz    <= f50_n;
            vp_err   <= err_n;
            period   <= period_n;
        end
    end
endmodule

// File: tb/tb_rx_vp_mon.sv
// tb_rx_vp_mon: directed plus randomized vsync trains checked cycle by cycle against an edge-level reference model
module tb_rx_vp_mon;
    localparam int PW       = 22;
    localparam int F59_MIN  = 200;
    localparam int F59_MAX  = 220;
    localparam int F50_MIN  = 240;
    localparam int F50_MAX  = 260;
    localparam int TMO      = 300;
    localparam int LOCK_N   = 3;
    localparam int UNLOCK_N = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vs_in = 1'b0;
    logic rx_vp, rx_ok, f50hz, vp_err;
    logic [PW-1:0] period;
    rx_vp_mon #(
        .PW(PW), .F59_MIN(F59_MIN), .F59_MAX(F59_MAX), .F50_MIN(F50_MIN),
        .F50_MAX(F50_MAX), .TMO(TMO), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N)
    ) dut (
        .clk(clk), .rst(rst), .vs_in(vs_in), .rx_vp(rx_vp), .rx_ok(rx_ok),
        .f50hz(f50hz), .vp_err(vp_err), .period(period)
    );
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_edge = 0;
    int edge_q[$];
    bit m_acq, m_lock, m_ok, m_f50, m_vp, m_err;
    int m_period, trk, run, miss;
    function automatic int classify(int n);
        return (n >= F59_MIN && n <= F59_MAX) ? 1 : (n >= F50_MIN && n <= F50_MAX) ? 2 : 0;
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask
    task automatic model_reset();
        edge_q.delete();
        m_acq = 0; m_lock = 0; m_ok = 0; m_f50 = 0; m_vp = 0; m_err = 0;
        m_period = 0; run = 0; miss = 0; trk = 1;
    endtask
    task automatic model_edge();
        int n = cyc - last_edge;
        int k = classify(n);
        last_edge = cyc;
        if (!m_acq && !m_lock) begin
            m_acq = 1;
            run = 0;
        end else begin
            m_period = n;
            if (m_acq) begin
                if (k == 0) begin
                    m_err = 1;
                    run = 0;
                end else if (k != trk) begin
                    trk = k;
                    run = 1;
                end else begin
                    run++;
                    if (run == LOCK_N) begin
                        m_acq = 0; m_lock = 1; m_ok = 1; m_f50 = (k == 2); miss = 0; m_vp = 1;
                    end
                end
            end else if (k == trk) begin
                m_vp = 1;
                miss = 0;
            end else begin
                m_err = 1;
                miss++;
                if (miss == UNLOCK_N) begin
                    m_lock = 0; m_acq = 1; m_ok = 0; run = 0;
                end
            end
        end
    endtask
    task automatic check_all();
        chk("rx_vp", 32'(rx_vp), 32'(m_vp));
        chk("vp_err", 32'(vp_err), 32'(m_err));
        chk("rx_ok", 32'(rx_ok), 32'(m_ok));
        chk("f50hz", 32'(f50hz), 32'(m_f50));
        chk("period", 32'(period), 32'(m_period));
    endtask
    task automatic step();
        @(posedge clk);
        cyc++;
        m_vp = 0;
        m_err = 0;
        if (rst) model_reset();
        else if (edge_q.size() > 0 && edge_q[0] == cyc) begin
            void'(edge_q.pop_front());
            model_edge();
        end else if ((m_acq || m_lock) && cyc - last_edge == TMO) begin
            m_acq = 0; m_lock = 0; m_ok = 0;
        end
        #1;
        check_all();
    endtask
    // rising vs_in after clock c is seen by the DUT as an edge registered at clock c+3
    task automatic pulse(int gap);
        int hi = $urandom_range(1, 8);
        vs_in = 1'b1;
        edge_q.push_back(cyc + 3);
        repeat (hi) step();
        vs_in = 1'b0;
        repeat (gap - hi) step();
    endtask
    initial begin
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        step();
        repeat (6) pulse(210);
        repeat (TMO + 50) step();
        repeat (5) pulse(250);
        repeat (7) pulse(210);
        pulse(150);
        repeat (3) pulse(210);
        repeat (TMO + 50) step();
        repeat (4) pulse(210);
        pulse(300);
        repeat (3) pulse(210);
        repeat (5) pulse(250);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (3) step();
        rst = 1'b0;
        step();
        repeat (5) pulse(210);
        for (int r = 0; r < 14; r++) begin
            int c = $urandom_range(0, 1);
            int len = $urandom_range(2, 6);
            for (int p = 0; p < len; p++) begin
                int sel = $urandom_range(0, 9);
                int g = c ? $urandom_range(F50_MIN, F50_MAX) : $urandom_range(F59_MIN, F59_MAX);
                if (sel == 0) g = $urandom_range(150, 199);
                else if (sel == 1) g = TMO;
                else if (sel == 2) g = $urandom_range(TMO + 1, TMO + 30);
                pulse(g);
            end
        end
        repeat (TMO + 20) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
